// File: rtl/smart_bulb_ctrl.sv
// Bulb-side controller for the smart_link lighting interface: samples the BULB
// signals and drives PWM-dimmed R/G/B enables with period-aligned level/colour updates.
module smart_bulb_ctrl #(
    parameter int BRIGHT_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                on_off,
    input  logic [BRIGHT_W-1:0] brightness,
    input  logic [1:0]          color,
    output logic                led_r,
    output logic                led_g,
    output logic                led_b,
    output logic                lamp_on,
    output logic [BRIGHT_W-1:0] cur_level,
    output logic [1:0]          cur_color,
    output logic                cfg_chg
);

    typedef enum logic [1:0] {
        WHITE = 2'd0,
        RED   = 2'd1,
        BLUE  = 2'd2,
        GREEN = 2'd3
    } color_e;

    localparam int                LMAX     = (1 << BRIGHT_W) - 1;
    localparam logic [BRIGHT_W-1:0] CNT_LAST = BRIGHT_W'(LMAX - 1);

    logic                on_q;
    logic [BRIGHT_W-1:0] bri_q;
    logic [1:0]          col_q;
    logic [BRIGHT_W-1:0] cnt;

    logic                wrap;
    logic [BRIGHT_W-1:0] cnt_nxt;
    logic [BRIGHT_W-1:0] lvl_nxt;
    logic [1:0]          col_nxt;
    logic                pwm_nxt;
    logic                chg;
    logic                r_en;
    logic                g_en;
    logic                b_en;

    // LEDs are registered from the next-state values, so in every cycle they
    // equal (cnt < cur_level) decoded by cur_color as seen on the outputs.
    // NOTE: every signal gets an unconditional value at the top of always_comb so no latch is inferred.
    always_comb begin
        wrap    = (cnt == CNT_LAST);
        cnt_nxt = wrap ? '0 : cnt + BRIGHT_W'(1);
        lvl_nxt = cur_level;
        col_nxt = cur_color;
        if (wrap) begin
            lvl_nxt = bri_q;
            col_nxt = col_q;
        end
        if (!on_q) begin
            lvl_nxt = '0;
        end
        pwm_nxt = (cnt_nxt < lvl_nxt);
        chg     = (on_off != on_q) || (brightness != bri_q) || (color != col_q);
        r_en    = (col_nxt == WHITE) || (col_nxt == RED);
        g_en    = (col_nxt == WHITE) || (col_nxt == GREEN);
        b_en    = (col_nxt == WHITE) || (col_nxt == BLUE);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            on_q      <= 1'b0;
            bri_q     <= '0;
            col_q     <= 2'd0;
            cnt       <= '0;
            cur_level <= '0;
            cur_color <= 2'd0;
            cfg_chg   <= 1'b0;
            led_r     <= 1'b0;
            led_g     <= 1'b0;
            led_b     <= 1'b0;
        end else begin
            on_q      <= on_off;
            bri_q     <= brightness;
            col_q     <= color;
            cnt       <= cnt_nxt;
            cur_level <= lvl_nxt;
            cur_color <= col_nxt;
            cfg_chg   <= chg;
            led_r     <= pwm_nxt && r_en;
            led_g     <= pwm_nxt && g_en;
            led_b     <= pwm_nxt && b_en;
        end
    end

    assign lamp_on = on_q;

endmodule

// File: tb/tb_smart_bulb_ctrl.sv
// Scoreboard bench for smart_bulb_ctrl: a cycle model pushes expected outputs
// when inputs are driven; they are popped and compared just after each rising edge.
module tb_smart_bulb_ctrl;

    localparam int BW   = 4;
    localparam int LMAX = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          on_off = 1'b0;
    logic [BW-1:0] brightness = '0;
    logic [1:0]    color = 2'd0;
    logic          led_r, led_g, led_b, lamp_on, cfg_chg;
    logic [BW-1:0] cur_level;
    logic [1:0]    cur_color;

    smart_bulb_ctrl #(.BRIGHT_W(BW)) dut (
        .clk        (clk),
        .rst        (rst),
        .on_off     (on_off),
        .brightness (brightness),
        .color      (color),
        .led_r      (led_r),
        .led_g      (led_g),
        .led_b      (led_b),
        .lamp_on    (lamp_on),
        .cur_level  (cur_level),
        .cur_color  (cur_color),
        .cfg_chg    (cfg_chg)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          r;
        logic          g;
        logic          b;
        logic          on;
        logic [BW-1:0] lvl;
        logic [1:0]    col;
        logic          chg;
    } obs_t;

    obs_t exp_q[$];
    obs_t last;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Reference model state (values visible after the most recent edge)
    int            m_cnt;
    logic          m_on;
    logic [BW-1:0] m_bri;
    logic [1:0]    m_col;
    logic [BW-1:0] m_lvl;
    logic [1:0]    m_colr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic model_reset();
        m_cnt  = 0;
        m_on   = 1'b0;
        m_bri  = '0;
        m_col  = 2'd0;
        m_lvl  = '0;
        m_colr = 2'd0;
        exp_q.delete();
    endtask

    task automatic model_edge(input logic on, input logic [BW-1:0] bri, input logic [1:0] col,
                              output obs_t e);
        logic       wrap;
        logic       pwm;
        logic [2:0] rgb;
        e.chg = (on !== m_on) || (bri !== m_bri) || (col !== m_col);
        wrap  = (m_cnt == LMAX - 1);
        if (!m_on)     m_lvl = '0;
        else if (wrap) m_lvl = m_bri;
        if (wrap)      m_colr = m_col;
        m_cnt = wrap ? 0 : m_cnt + 1;
        m_on  = on;
        m_bri = bri;
        m_col = col;
        pwm   = (m_cnt < int'(m_lvl));
        case (m_colr)
            2'd0:    rgb = 3'b111;
            2'd1:    rgb = 3'b100;
            2'd2:    rgb = 3'b001;
            default: rgb = 3'b010;
        endcase
        if (!pwm) rgb = 3'b000;
        e.r   = rgb[2];
        e.g   = rgb[1];
        e.b   = rgb[0];
        e.on  = m_on;
        e.lvl = m_lvl;
        e.col = m_colr;
    endtask

    task automatic step(input logic on, input logic [BW-1:0] bri, input logic [1:0] col,
                        input string tag);
        obs_t e;
        obs_t want;
        on_off     = on;
        brightness = bri;
        color      = col;
        model_edge(on, bri, col, e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        last = {led_r, led_g, led_b, lamp_on, cur_level, cur_color, cfg_chg};
        want = exp_q.pop_front();
        check_eq($sformatf("%s@%0d", tag, cyc), last, want);
    endtask

    int n_r, n_g, n_b, n_all, n_any, n_chg;
    logic found;

    task automatic count_period(input logic on, input logic [BW-1:0] bri, input logic [1:0] col,
                                input string tag);
        n_r = 0; n_g = 0; n_b = 0; n_all = 0; n_any = 0; n_chg = 0;
        for (int i = 0; i < LMAX; i++) begin
            step(on, bri, col, tag);
            n_r   += int'(last.r);
            n_g   += int'(last.g);
            n_b   += int'(last.b);
            n_all += int'(last.r & last.g & last.b);
            n_any += int'(last.r | last.g | last.b);
            n_chg += int'(last.chg);
        end
    endtask

    initial begin
        model_reset();
        // 1: reset held with live inputs, then released with inputs at zero
        on_off = 1'b1; brightness = 4'd15; color = 2'd1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_outputs", {led_r, led_g, led_b, lamp_on, cur_level, cur_color, cfg_chg}, '0);
        @(negedge clk);
        on_off = 1'b0; brightness = '0; color = 2'd0;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) step(1'b0, 4'd0, 2'd0, "rel");
        check_eq("rel_quiet", last, '0);

        // 2: party RED at full level
        step(1'b1, 4'd15, 2'd1, "party");
        check_eq("party_cfg", last.chg, 1);
        step(1'b1, 4'd15, 2'd1, "party");
        check_eq("party_cfg_one", last.chg, 0);
        for (int i = 0; i < LMAX; i++) step(1'b1, 4'd15, 2'd1, "party");
        count_period(1'b1, 4'd15, 2'd1, "party_p");
        check_eq("party_r_duty", n_r, 15);
        check_eq("party_gb_off", n_g + n_b, 0);
        check_eq("party_level", last.lvl, 15);
        check_eq("party_color", last.col, 1);

        // 3: movie BLUE at level 5
        count_period(1'b1, 4'd5, 2'd2, "movie_x");
        check_eq("movie_cfg_pulses", n_chg, 1);
        count_period(1'b1, 4'd5, 2'd2, "movie_p");
        check_eq("movie_b_duty", n_b, 5);
        check_eq("movie_rg_off", n_r + n_g, 0);

        // 4: switch off while the counter sits at 2
        for (int i = 0; i < 2 * LMAX && m_cnt != 2; i++) step(1'b1, 4'd5, 2'd2, "seek");
        step(1'b0, 4'd5, 2'd2, "off");
        check_eq("off_lamp", last.on, 0);
        check_eq("off_cfg", last.chg, 1);
        step(1'b0, 4'd5, 2'd2, "off");
        check_eq("off_leds", {last.r, last.g, last.b}, 0);
        check_eq("off_level", last.lvl, 0);
        for (int i = 0; i < 5; i++) step(1'b0, 4'd5, 2'd2, "off");

        // 5: WHITE at level 0, then level 15
        count_period(1'b1, 4'd0, 2'd0, "w0_x");
        count_period(1'b1, 4'd0, 2'd0, "w0_p");
        check_eq("w0_dark", n_any, 0);
        check_eq("w0_lamp", last.on, 1);
        count_period(1'b1, 4'd15, 2'd0, "w15_x");
        count_period(1'b1, 4'd15, 2'd0, "w15_p");
        check_eq("w15_all_on", n_all, 15);

        // 6: asynchronous reset while led_b is high
        found = 1'b0;
        for (int i = 0; i < 3 * LMAX && !found; i++) begin
            step(1'b1, 4'd5, 2'd2, "pre6");
            found = last.b;
        end
        check_eq("led_b_seen", found, 1);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_led_b", led_b, 0);
        check_eq("arst_all", {led_r, led_g, led_b, lamp_on, cur_level, cur_color, cfg_chg}, '0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 2 * LMAX + 3; i++) step(1'b1, 4'd5, 2'd2, "post6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
